// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch unit constants: state encoding, operand-count decode, timeout limit
package fetch_unit_pkg;

  // Legacy-compatible 2-bit state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_ADV      = 2'd2;
  localparam logic [1:0] ST_DISPATCH = 2'd3;

  // Number of consecutive unacknowledged REQ cycles that raise fetch_fault
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // Instruction as assembled for the decoder
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
  } instr_t;

  // Operand byte count from opcode[7:6]; the 11 encoding carries no operands
  function automatic logic [1:0] operand_count(input logic [1:0] sel);
    case (sel)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory read and decoder handshake bundle for the fetch unit
interface fetch_unit_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;

  // Fetch unit side
  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_ack,
    output instr_valid, instr_opcode, instr_operand, instr_len,
    input  instr_ready
  );

  // Memory / decoder side
  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_ack,
    input  instr_valid, instr_opcode, instr_operand, instr_len,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch FSM; FETCH_TIMEOUT_EN adds a sticky memory-timeout fault
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [15:0]  pc_in,
  output logic         pc_inc,
  output logic         ir_write,
  output logic [7:0]   bus_data,
  output logic         fetch_fault,
  fetch_unit_if.master bus
);

  logic [1:0] state;
  logic [1:0] byte_idx;   // bytes of the current instruction already advanced past
  logic [7:0] data_q;     // byte captured on the ack cycle, driven out during ADV
  instr_t     instr_q;
  logic       timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       fault_q;

  assign timeout_hit = (state == ST_REQ) && !bus.mem_ack &&
                       (wait_cnt == TIMEOUT_LIMIT - 8'd1);
  assign fetch_fault = fault_q;

  // Count unacknowledged REQ cycles; latch the fault when the limit is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else if ((state == ST_REQ) && !bus.mem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit) fault_q <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Fetch sequencing: request a byte, advance the PC, repeat for operands, then dispatch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_idx <= 2'd0;
      data_q   <= 8'h00;
      instr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_idx <= 2'd0;
          // A latched fault keeps the unit parked here until reset
          if (run && !fetch_fault) state <= ST_REQ;
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            data_q <= bus.mem_rdata;
            if (byte_idx == 2'd0) begin
              instr_q.opcode  <= bus.mem_rdata;
              instr_q.operand <= 16'h0000;
              instr_q.len     <= operand_count(bus.mem_rdata[7:6]);
            end else if (byte_idx == 2'd1) begin
              instr_q.operand[7:0] <= bus.mem_rdata;
            end else begin
              instr_q.operand[15:8] <= bus.mem_rdata;
            end
            state <= ST_ADV;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_ADV: begin
          if (byte_idx == instr_q.len) begin
            state <= ST_DISPATCH;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            state    <= ST_REQ;
          end
        end
        ST_DISPATCH: begin
          if (bus.instr_ready) begin
            byte_idx <= 2'd0;
            state    <= run ? ST_REQ : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs so reset drops them without waiting for a clock
  assign bus.mem_req       = (state == ST_REQ);
  assign bus.mem_addr      = (state == ST_REQ) ? pc_in : 16'h0000;
  assign pc_inc            = (state == ST_ADV);
  assign ir_write          = (state == ST_ADV) && (byte_idx == 2'd0);
  assign bus_data          = (state == ST_ADV) ? data_q : 8'h00;
  assign bus.instr_valid   = (state == ST_DISPATCH);
  assign bus.instr_opcode  = instr_q.opcode;
  assign bus.instr_operand = instr_q.operand;
  assign bus.instr_len     = instr_q.len;

endmodule
